fx_dac_out: RTL and testbench
=============================

# fx_dac_out

Output stage between the last FX in the chain (output gain) and the audio codec's DAC sink ports. It captures each stereo FX result on the pipeline's final sample-enable strobe and applies a click-free soft-mute gain ramp. It buffers the result in a small stereo FIFO and drives the codec's independent left/right Avalon-ST valid/ready sinks, popping an entry only when both channels have accepted it. It also reports FIFO fill level and overflow statistics for debug LEDs and SignalTap.

## Interface
- DATA_W, 16, audio sample width (signed two's complement)
- FIFO_DEPTH, 8, stereo entries; power of two, ≥2
- RAMP_STEP, 32, gain increment/decrement per sample_en (gain unity = 256)

- clk  in  1  system clock (CLOCK_50)
- reset  in  1  synchronous, active-high; one clock, sampled on rising edge of clk
- audio_in  in  [1:0][DATA_W]  FX chain output, index 0 = left, 1 = right
- sample_en  in  1  one-cycle strobe, audio_in valid this cycle
- mute  in  1  level; 1 = ramp to silence, 0 = ramp to unity
- dac_data  out  [1:0][DATA_W]  to codec to_dac_*_channel_data
- dac_valid  out  [1:0]  to codec to_dac_*_channel_valid
- dac_ready  in  [1:0]  from codec to_dac_*_channel_ready
- fill  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky; set on any dropped sample
- overflow_cnt  out  8  dropped-sample count, saturates at 255
- stat_clr  in  1  clears overflow and overflow_cnt
- muted  out  1  high while gain == 0 and mute == 1

## Operation
- Gain register g, 9-bit unsigned, 0..256. FSM states: RAMP_UP, UNMUTED, RAMP_DOWN, MUTED.
- Each sample_en: sample scaled by g as held before this cycle's update; then g updates.
  - mute=0: g = min(g+RAMP_STEP, 256). State is UNMUTED if the result is 256, else RAMP_UP.
  - mute=1: g = max(g−RAMP_STEP, 0). State is MUTED if the result is 0, else RAMP_DOWN.
- mute changing mid-ramp reverses direction from the current g; there is no jump.
- g changes only on sample_en.
- Scaling per channel: out = (audio_in × {1'b0,g}) >>> 8.
  - Signed product, DATA_W+10 bits; arithmetic shift, floor rounding.
  - Result fits DATA_W with no saturation. g=256 gives bit-exact passthrough.
- Scale register (stage S) loads on sample_en. A push of stage S occurs on the next cycle.
- Push accepted if fill < FIFO_DEPTH, or if fill == FIFO_DEPTH and a pop occurs the same cycle.
- Otherwise the pair is dropped: overflow is set and overflow_cnt increments, saturating at 255.
- Read side:
  - Head entry is presented on dac_data[0]/[1].
  - Per-channel done flags d[1:0].
  - dac_valid[c] = (fill != 0) && !d[c].
  - A handshake (valid && ready) sets d[c].
  - Pop when both channels have completed. Completion may be in the same cycle or separate cycles.
  - Pop clears d[1:0] and advances the read pointer.
- dac_data is stable while dac_valid[c] is high and not accepted.
- Pointers wrap modulo FIFO_DEPTH.
- stat_clr has priority over a same-cycle overflow increment; the result is 0.

## Timing
- Reset values:
  - dac_valid=0, dac_data=0, fill=0, overflow=0, overflow_cnt=0, d=0.
  - g=0, state RAMP_UP, muted=0.
  - Startup therefore fades in.
- Latency: sample_en at edge N → entry written at edge N+1 → dac_valid high in the cycle after edge N+1, if the FIFO was empty.
- The stereo pair leaves no earlier than 2 cycles after sample_en. With ready held high it leaves exactly then.
- fill updates the cycle after push/pop. A simultaneous push and pop leaves fill unchanged.
- reset mid-handshake discards the FIFO contents and drops valid on the next cycle.
- muted is registered and updates the cycle after g reaches 0.

## Test plan
- **Fade-in:** reset, mute=0, RAMP_STEP=32, audio_in=16384 on 10 strobes → left outputs 0, 2048, 4096 … 14336, 16384, 16384; state UNMUTED after the 8th strobe.
- **Floor rounding:** g=256 with input −1 → −1; g=128 with inputs −256 / −1 / 255 → −128 / −1 / 127.
- **Mute reversal:** from unity, mute=1 for 3 strobes (g=160), then mute=0 → g goes 192, 224, 256; no step larger than 32. Hold mute for 8 strobes → muted=1, outputs 0.
- **Split handshake:** dac_ready=2'b01 for 5 cycles, then 2'b10 → left accepted once and not re-presented; pop occurs only after right accepts; fill goes 1→0.
- **Overflow:** dac_ready=0, 12 strobes with FIFO_DEPTH=8 → fill=8, overflow=1, overflow_cnt=4. Then stat_clr → both read 0. Release ready → the first 8 samples drain in order.
- **Full with simultaneous pop:** fill=8, strobe timed so its push coincides with a pop → push accepted, fill stays 8, overflow_cnt unchanged.

Source files
------------

// File: rtl/fx_dac_out.sv
// fx_dac_out: final output stage of the FX chain. Applies a soft-mute gain
// ramp, buffers stereo pairs in a small FIFO and feeds the codec's
// independent left/right valid/ready DAC sinks, popping only once both
// channels have taken the head entry.
`timescale 1ns/1ps

module fx_dac_out #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned RAMP_STEP  = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [1:0][DATA_W-1:0]        audio_in,
    input  logic                          sample_en,
    input  logic                          mute,
    output logic [1:0][DATA_W-1:0]        dac_data,
    output logic [1:0]                    dac_valid,
    input  logic [1:0]                    dac_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fill,
    output logic                          overflow,
    output logic [7:0]                    overflow_cnt,
    input  logic                          stat_clr,
    output logic                          muted
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned FW = AW + 1;
    localparam int unsigned PW = DATA_W + 10;
    localparam logic [9:0]    Step    = 10'(RAMP_STEP);
    localparam logic [9:0]    Unity   = 10'd256;
    localparam logic [AW-1:0] PtrInc  = AW'(1);
    localparam logic [AW:0]   FillInc = FW'(1);
    localparam logic [AW:0]   Depth   = FW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StRampUp, StUnmuted, StRampDown, StMuted} state_e;

    state_e      state_q, state_d;
    logic [8:0]  g_q, g_d;
    logic [9:0]  g_up;
    logic        muted_q, muted_d;

    logic signed [PW-1:0]     a_ext [2];
    logic signed [PW-1:0]     g_ext;
    logic signed [PW-1:0]     prod  [2];
    logic [1:0][DATA_W-1:0]   scaled;

    logic                     s_vld_q;
    logic [1:0][DATA_W-1:0]   s_data_q;

    logic [1:0][DATA_W-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr_q, rd_ptr_q;
    logic [AW:0]              fill_q, fill_d;
    logic [1:0]               done_q;
    logic [1:0]               hs;
    logic                     not_empty, full, push, pop, drop;

    logic                     overflow_q;
    logic [7:0]               ovf_cnt_q;

    // Gain FSM state register, gain value and registered mute indicator
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StRampUp;
            g_q     <= '0;
            muted_q <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            muted_q <= muted_d;
        end
    end

    // Gain FSM next state: step toward unity or silence once per sample strobe
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        g_up    = {1'b0, g_q} + Step;
        if (sample_en) begin
            if (!mute) begin
                if (g_up >= Unity) begin
                    g_d     = 9'(Unity);
                    state_d = StUnmuted;
                end else begin
                    g_d     = g_up[8:0];
                    state_d = StRampUp;
                end
            end else begin
                if ({1'b0, g_q} <= Step) begin
                    g_d     = '0;
                    state_d = StMuted;
                end else begin
                    g_d     = 9'({1'b0, g_q} - Step);
                    state_d = StRampDown;
                end
            end
        end
    end

    // Gain FSM outputs: muted flag follows the current gain, registered above
    always_comb begin
        muted_d = (g_q == 9'd0) && mute;
    end

    assign muted = muted_q;

    // Signed scaling by the pre-update gain; >>> 8 floors, g=256 is passthrough
    always_comb begin
        g_ext = $signed({{(DATA_W + 1){1'b0}}, g_q});
        for (int c = 0; c < 2; c++) begin
            a_ext[c]  = $signed({{10{audio_in[c][DATA_W-1]}}, audio_in[c]});
            prod[c]   = a_ext[c] * g_ext;
            scaled[c] = DATA_W'(prod[c] >>> 8);
        end
    end

    // Stage S: capture the scaled pair on the strobe, push it one cycle later
    always_ff @(posedge clk) begin
        if (reset) begin
            s_vld_q  <= 1'b0;
            s_data_q <= '0;
        end else begin
            s_vld_q <= sample_en;
            if (sample_en) begin
                s_data_q <= scaled;
            end
        end
    end

    // Read-side handshake, pop/push decisions and next fill level
    always_comb begin
        not_empty = (fill_q != '0);
        full      = (fill_q == Depth);
        dac_valid = {2{not_empty}} & ~done_q;
        hs        = dac_valid & dac_ready;
        pop       = not_empty && ((done_q | hs) == 2'b11);
        // A full FIFO still takes the pair if the head leaves this same cycle
        push      = s_vld_q && (!full || pop);
        drop      = s_vld_q && !push;
        dac_data  = not_empty ? mem[rd_ptr_q] : '0;
        fill_d    = fill_q;
        if (push && !pop) begin
            fill_d = fill_q + FillInc;
        end else if (pop && !push) begin
            fill_d = fill_q - FillInc;
        end
    end

    // FIFO pointers, occupancy and per-channel done flags
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            done_q   <= '0;
        end else begin
            fill_q <= fill_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrInc;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrInc;
                done_q   <= '0;
            end else begin
                done_q <= done_q | hs;
            end
        end
    end

    // FIFO storage; contents need no reset since fill gates visibility
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= s_data_q;
        end
    end

    // Overflow statistics; clear wins over a same-cycle drop
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
            ovf_cnt_q  <= '0;
        end else if (stat_clr) begin
            overflow_q <= 1'b0;
            ovf_cnt_q  <= '0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (ovf_cnt_q != 8'hff) begin
                ovf_cnt_q <= ovf_cnt_q + 8'd1;
            end
        end
    end

    assign fill         = fill_q;
    assign overflow     = overflow_q;
    assign overflow_cnt = ovf_cnt_q;

endmodule

// File: tb/tb_fx_dac_out.sv
// Directed bench for fx_dac_out: fade-in, rounding, mute reversal, split
// handshake, overflow and full-with-pop behaviour.
`timescale 1ns/1ps

module tb_fx_dac_out;

    logic              clk;
    logic              reset;
    logic [1:0][15:0]  audio_in;
    logic              sample_en;
    logic              mute;
    logic [1:0][15:0]  dac_data;
    logic [1:0]        dac_valid;
    logic [1:0]        dac_ready;
    logic [3:0]        fill;
    logic              overflow;
    logic [7:0]        overflow_cnt;
    logic              stat_clr;
    logic              muted;

    int checks = 0;
    int errors = 0;

    logic signed [15:0] ql[$];
    logic signed [15:0] qr[$];

    int rev_exp[9] = '{160, 192, 224, 256, 224, 192, 160, 192, 224};

    fx_dac_out #(
        .DATA_W     (16),
        .FIFO_DEPTH (8),
        .RAMP_STEP  (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .audio_in     (audio_in),
        .sample_en    (sample_en),
        .mute         (mute),
        .dac_data     (dac_data),
        .dac_valid    (dac_valid),
        .dac_ready    (dac_ready),
        .fill         (fill),
        .overflow     (overflow),
        .overflow_cnt (overflow_cnt),
        .stat_clr     (stat_clr),
        .muted        (muted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every accepted sample per channel
    always @(posedge clk) begin
        if (!reset) begin
            if (dac_valid[0] && dac_ready[0]) ql.push_back(dac_data[0]);
            if (dac_valid[1] && dac_ready[1]) qr.push_back(dac_data[1]);
        end
    end

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_pair(input string tag, input int idx, input int el, input int er);
        logic signed [31:0] ol;
        logic signed [31:0] orr;
        ol  = 'x;
        orr = 'x;
        if (idx < ql.size()) ol = 32'(ql[idx]);
        if (idx < qr.size()) orr = 32'(qr[idx]);
        chk({tag, "_l"}, ol, el);
        chk({tag, "_r"}, orr, er);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe(input int l, input int r);
        audio_in[0] = 16'(l);
        audio_in[1] = 16'(r);
        sample_en   = 1'b1;
        @(negedge clk);
        sample_en   = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        sample_en = 1'b0;
        mute      = 1'b0;
        dac_ready = 2'b00;
        stat_clr  = 1'b0;
        audio_in  = '0;
        idle(3);

        // Reset state
        chk("rst_valid", 32'(dac_valid), 0);
        chk("rst_data", 32'(dac_data), 0);
        chk("rst_fill", 32'(fill), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_cnt", 32'(overflow_cnt), 0);
        chk("rst_muted", 32'(muted), 0);
        chk("rst_state", 32'(dut.state_q), 0);
        chk("rst_g", 32'(dut.g_q), 0);
        reset = 1'b0;

        // Fade-in from g=0
        dac_ready = 2'b11;
        for (int k = 1; k <= 10; k++) begin
            strobe(16384, -16384);
            chk("fade_g", 32'(dut.g_q), (32 * k > 256) ? 256 : 32 * k);
            if (k == 7) chk("fade_st7", 32'(dut.state_q), 0);
            if (k == 8) chk("fade_st8", 32'(dut.state_q), 1);
            idle(2);
        end
        idle(4);
        chk("fade_n", ql.size(), 10);
        for (int i = 0; i < 10; i++) begin
            chk_pair("fade", i, (i < 8) ? 2048 * i : 16384, (i < 8) ? -2048 * i : -16384);
        end

        // Floor rounding at g=256 and g=128
        ql.delete();
        qr.delete();
        strobe(-1, -1);
        idle(2);
        mute = 1'b1;
        repeat (4) begin
            strobe(0, 0);
            idle(2);
        end
        chk("rnd_g128", 32'(dut.g_q), 128);
        strobe(-256, -1);
        idle(2);
        mute = 1'b0;
        strobe(0, 0);
        idle(2);
        strobe(255, 100);
        idle(4);
        chk("rnd_n", ql.size(), 8);
        chk_pair("rnd256", 0, -1, -1);
        chk_pair("rnd128a", 5, -128, -1);
        chk_pair("rnd128b", 7, 127, 50);

        // Mute reversal: outputs equal the pre-update gain with input 256
        ql.delete();
        qr.delete();
        repeat (3) begin
            strobe(256, 256);
            idle(2);
        end
        chk("rev_unity", 32'(dut.g_q), 256);
        mute = 1'b1;
        repeat (3) begin
            strobe(256, 256);
            idle(2);
        end
        chk("rev_g160", 32'(dut.g_q), 160);
        chk("rev_st_down", 32'(dut.state_q), 2);
        mute = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            strobe(256, 256);
            chk("rev_up_g", 32'(dut.g_q), 160 + 32 * k);
            idle(2);
        end
        chk("rev_st_unm", 32'(dut.state_q), 1);
        idle(2);
        chk("rev_n", ql.size(), 9);
        for (int i = 0; i < 9; i++) chk_pair("rev", i, rev_exp[i], rev_exp[i]);

        // Hold mute to silence
        ql.delete();
        qr.delete();
        mute = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            strobe(256, 256);
            if (k < 8) idle(2);
        end
        chk("mute_g0", 32'(dut.g_q), 0);
        chk("mute_lag", 32'(muted), 0);
        idle(1);
        chk("mute_set", 32'(muted), 1);
        chk("mute_st", 32'(dut.state_q), 3);
        strobe(256, 256);
        idle(4);
        chk("mute_n", ql.size(), 9);
        chk_pair("mute_first", 0, 256, 256);
        chk_pair("mute_last", 7, 32, 32);
        chk_pair("mute_zero", 8, 0, 0);
        chk("mute_hold", 32'(muted), 1);

        // Ramp back to unity for the FIFO tests
        mute = 1'b0;
        repeat (8) begin
            strobe(0, 0);
            idle(2);
        end
        idle(4);
        chk("back_g", 32'(dut.g_q), 256);
        chk("back_muted", 32'(muted), 0);
        ql.delete();
        qr.delete();

        // Split handshake
        dac_ready = 2'b00;
        strobe(1000, 2000);
        idle(3);
        chk("split_fill1", 32'(fill), 1);
        chk("split_valid", 32'(dac_valid), 3);
        chk("split_data0", 32'($signed(dac_data[0])), 1000);
        dac_ready = 2'b01;
        idle(5);
        chk("split_vl_done", 32'(dac_valid), 2);
        chk("split_fill_hold", 32'(fill), 1);
        chk("split_nl", ql.size(), 1);
        chk("split_nr0", qr.size(), 0);
        chk("split_data1", 32'($signed(dac_data[1])), 2000);
        dac_ready = 2'b10;
        idle(1);
        chk("split_fill0", 32'(fill), 0);
        chk("split_valid0", 32'(dac_valid), 0);
        chk("split_nr", qr.size(), 1);
        chk_pair("split", 0, 1000, 2000);
        dac_ready = 2'b00;

        // Overflow with ready held low
        ql.delete();
        qr.delete();
        for (int k = 1; k <= 12; k++) begin
            strobe(100 * k, -100 * k);
            idle(1);
        end
        idle(2);
        chk("ovf_fill", 32'(fill), 8);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_cnt", 32'(overflow_cnt), 4);
        stat_clr = 1'b1;
        idle(1);
        stat_clr = 1'b0;
        chk("clr_flag", 32'(overflow), 0);
        chk("clr_cnt", 32'(overflow_cnt), 0);
        dac_ready = 2'b11;
        idle(12);
        chk("drain_fill", 32'(fill), 0);
        chk("drain_n", ql.size(), 8);
        for (int i = 0; i < 8; i++) chk_pair("drain", i, 100 * (i + 1), -100 * (i + 1));

        // Full FIFO with a push landing on the same edge as a pop
        dac_ready = 2'b00;
        ql.delete();
        qr.delete();
        for (int k = 1; k <= 8; k++) begin
            strobe(20 + k, -(20 + k));
            idle(1);
        end
        idle(2);
        chk("fp_fill8", 32'(fill), 8);
        strobe(29, -29);
        dac_ready = 2'b11;
        idle(1);
        dac_ready = 2'b00;
        chk("fp_fill", 32'(fill), 8);
        chk("fp_cnt", 32'(overflow_cnt), 0);
        chk("fp_flag", 32'(overflow), 0);
        chk("fp_pop1", ql.size(), 1);
        dac_ready = 2'b11;
        idle(12);
        chk("fp_n", ql.size(), 9);
        for (int i = 0; i < 9; i++) chk_pair("fp", i, 21 + i, -(21 + i));
        chk("fp_empty", 32'(fill), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
